// File: rtl/lcd_pkg.sv
// lcd_pkg -- shared definitions for the HD44780-style 4-bit LCD reader and writer.
//   lcd_state_t : bus-cycle state encoding (IDLE, SETUP, EHI1, ELO1, EHI2, HOLD, DONE)
//   DEF_*       : default timing constants in 27 MHz clock cycles
//   TMR_W       : width of the per-state cycle timer
//   cyc_load()  : converts a cycle count into the timer load value
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EHI1,
    ST_ELO1,
    ST_EHI2,
    ST_HOLD,
    ST_DONE
  } lcd_state_t;

  localparam int DEF_SETUP_CYC    = 2;      // 74 ns RS/RW setup before E rises
  localparam int DEF_EHIGH_CYC    = 8;      // 296 ns E high width
  localparam int DEF_ELOW_CYC     = 10;     // E low gap between nibbles
  localparam int DEF_HOLD_CYC     = 2;      // RW/RS hold after the last E fall
  localparam int DEF_POLL_TIMEOUT = 55000;  // 2 ms busy-poll limit

  localparam int TMR_W = 8;

  // The timer counts down to zero inclusive, so an N-cycle state loads N-1.
  function automatic logic [TMR_W-1:0] cyc_load(input int n);
    return (n > 0) ? TMR_W'(n - 1) : '0;
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// lcd_cycle_timer -- loadable down-counter sequencing per-state cycle counts.
//   Clk, Reset : clock, synchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : cycles-minus-one for the state being entered
//   done       : high on the last cycle of the current count
module lcd_cycle_timer
  import lcd_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] count_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - TMR_W'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/lcd_read.sv
// lcd_read -- 4-bit LCD read cycle generator with optional busy-flag polling.
//   Clk, Reset     : 27 MHz clock, synchronous active-high reset
//   Strb, RS, Poll : start request, register select, poll-until-not-busy (sampled when idle)
//   D_in[3:0]      : DB7..DB4 from the LCD
//   E, RW, RS_out  : LCD control lines (RW=1 means the top level tristates DB7..DB4)
//   Busy           : transaction in progress
//   D_out[7:0]     : assembled byte, high nibble first, updated only with Valid
//   Valid, Timeout : one-cycle pulses; Timeout marks a poll that gave up with busy still set
module lcd_read
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int EHIGH_CYC    = DEF_EHIGH_CYC,
  parameter int ELOW_CYC     = DEF_ELOW_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int POLL_TIMEOUT = DEF_POLL_TIMEOUT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Strb,
  input  logic       RS,
  input  logic       Poll,
  input  logic [3:0] D_in,
  output logic       E,
  output logic       RW,
  output logic       RS_out,
  output logic       Busy,
  output logic [7:0] D_out,
  output logic       Valid,
  output logic       Timeout
);

  localparam int             PW       = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PW-1:0]  POLL_MAX = PW'(POLL_TIMEOUT);

  lcd_state_t       state_reg;
  logic             e_reg, rw_reg, rs_out_reg, busy_reg, valid_reg, timeout_reg;
  logic             poll_reg;
  logic [7:0]       stage_reg, d_out_reg;
  logic [PW-1:0]    poll_cnt_reg;

  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;
  logic             lcd_busy_flag, poll_again;

  // The busy flag is DB7 of a status read; it is only meaningful with RS=0.
  assign lcd_busy_flag = poll_reg && !rs_out_reg && stage_reg[7];
  assign poll_again    = lcd_busy_flag && (poll_cnt_reg < POLL_MAX);

  // Timer is reloaded on every state change that starts a timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_reg)
      ST_IDLE, ST_DONE: if (Strb) begin tmr_load = 1'b1; tmr_val = cyc_load(SETUP_CYC); end
      ST_SETUP: if (tmr_done) begin tmr_load = 1'b1; tmr_val = cyc_load(EHIGH_CYC); end
      ST_EHI1:  if (tmr_done) begin tmr_load = 1'b1; tmr_val = cyc_load(ELOW_CYC);  end
      ST_ELO1:  if (tmr_done) begin tmr_load = 1'b1; tmr_val = cyc_load(EHIGH_CYC); end
      ST_EHI2:  if (tmr_done) begin tmr_load = 1'b1; tmr_val = cyc_load(HOLD_CYC);  end
      ST_HOLD:  if (tmr_done && poll_again) begin tmr_load = 1'b1; tmr_val = cyc_load(SETUP_CYC); end
      default: ;
    endcase
  end

  lcd_cycle_timer u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= ST_IDLE;
      e_reg        <= 1'b0;
      rw_reg       <= 1'b0;
      rs_out_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
      poll_reg     <= 1'b0;
      stage_reg    <= 8'h00;
      d_out_reg    <= 8'h00;
      poll_cnt_reg <= '0;
    end else begin
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      if (busy_reg && poll_cnt_reg != POLL_MAX) begin
        poll_cnt_reg <= poll_cnt_reg + PW'(1);
      end
      case (state_reg)
        // DONE accepts a new request directly so a held Strb drops RW for one cycle only.
        ST_IDLE, ST_DONE: begin
          state_reg <= ST_IDLE;
          if (Strb) begin
            state_reg    <= ST_SETUP;
            rs_out_reg   <= RS;
            poll_reg     <= Poll;
            rw_reg       <= 1'b1;
            busy_reg     <= 1'b1;
            poll_cnt_reg <= '0;
          end
        end
        ST_SETUP: if (tmr_done) begin
          state_reg <= ST_EHI1;
          e_reg     <= 1'b1;
        end
        ST_EHI1: if (tmr_done) begin
          state_reg       <= ST_ELO1;
          stage_reg[7:4]  <= D_in;
          e_reg           <= 1'b0;
        end
        ST_ELO1: if (tmr_done) begin
          state_reg <= ST_EHI2;
          e_reg     <= 1'b1;
        end
        ST_EHI2: if (tmr_done) begin
          state_reg      <= ST_HOLD;
          stage_reg[3:0] <= D_in;
          e_reg          <= 1'b0;
        end
        ST_HOLD: if (tmr_done) begin
          if (poll_again) begin
            state_reg <= ST_SETUP;
          end else begin
            state_reg   <= ST_DONE;
            d_out_reg   <= stage_reg;
            valid_reg   <= 1'b1;
            timeout_reg <= lcd_busy_flag;
            rw_reg      <= 1'b0;
            busy_reg    <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign E       = e_reg;
  assign RW      = rw_reg;
  assign RS_out  = rs_out_reg;
  assign Busy    = busy_reg;
  assign D_out   = d_out_reg;
  assign Valid   = valid_reg;
  assign Timeout = timeout_reg;

endmodule

// File: tb/tb_lcd_read.sv
// tb_lcd_read -- self-checking bench for lcd_read with POLL_TIMEOUT=200.
// A transaction-level model predicts every output from the position inside
// the 30-cycle read frame (2 setup, 8 E high, 10 E low, 8 E high, 2 hold).
module tb_lcd_read;

  localparam int PT = 200;

  logic       Clk = 1'b0;
  logic       Reset, Strb, RS, Poll;
  logic [3:0] D_in;
  logic       E, RW, RS_out, Busy, Valid, Timeout;
  logic [7:0] D_out;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  lcd_read #(.POLL_TIMEOUT(PT)) dut (
    .Clk(Clk), .Reset(Reset), .Strb(Strb), .RS(RS), .Poll(Poll), .D_in(D_in),
    .E(E), .RW(RW), .RS_out(RS_out), .Busy(Busy), .D_out(D_out),
    .Valid(Valid), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_act;
  int         m_p, m_bcnt;
  bit         m_poll, m_rs;
  logic [3:0] m_hi, m_lo;
  logic       exp_e, exp_rw, exp_busy, exp_valid, exp_to, exp_rs;
  logic [7:0] exp_dout;

  always @(posedge Clk) begin
    if (Reset) begin
      m_act = 0; m_p = 0; m_bcnt = 0; m_poll = 0; m_rs = 0;
      m_hi = 0; m_lo = 0; exp_valid = 0; exp_to = 0; exp_dout = 8'h00; exp_rs = 0;
    end else begin
      exp_valid = 0;
      exp_to    = 0;
      if (m_act) begin
        if (m_p == 9)  m_hi = D_in;
        if (m_p == 27) m_lo = D_in;
        if (m_p == 29) begin
          if (m_poll && !m_rs && m_hi[3] && m_bcnt < PT) m_p = 0;
          else begin
            m_act = 0; exp_valid = 1;
            exp_to = m_poll && !m_rs && m_hi[3];
            exp_dout = {m_hi, m_lo};
          end
        end else m_p++;
        m_bcnt = (m_bcnt + 1 > PT) ? PT : m_bcnt + 1;
      end else if (Strb) begin
        m_act = 1; m_p = 0; m_rs = RS; m_poll = Poll; m_bcnt = 0; exp_rs = RS;
      end
    end
    exp_busy = m_act;
    exp_rw   = m_act;
    exp_e    = m_act && ((m_p >= 2 && m_p <= 9) || (m_p >= 20 && m_p <= 27));
  end

  always @(negedge Clk) begin
    if (armed) begin
      chk("E", E, exp_e);
      chk("RW", RW, exp_rw);
      chk("Busy", Busy, exp_busy);
      chk("RS_out", RS_out, exp_rs);
      chk("Valid", Valid, exp_valid);
      chk("Timeout", Timeout, exp_to);
      chk("D_out", D_out, exp_dout);
      if (E && !RW) chk("E_without_RW", 1'b1, 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((Busy || Valid) && n < 400) begin tick(); n++; end
    if (n >= 400) chk({name, "_idle_timeout"}, 16'd1, 16'd0);
    tick();
  endtask

  initial begin
    int n, ehi, run, maxrun, runs, erises, vcnt, vcyc, lowrun, seen;
    logic [7:0] vd;
    logic prev_e, vto, vbusy;

    Reset = 1; Strb = 0; RS = 0; Poll = 0; D_in = 4'h0;
    tick(); armed = 1'b1; tick(); tick();
    Reset = 0;
    chk("rst_E", E, 0); chk("rst_RW", RW, 0); chk("rst_Busy", Busy, 0);
    chk("rst_D_out", D_out, 8'h00); chk("rst_Valid", Valid, 0); chk("rst_Timeout", Timeout, 0);
    tick();

    // Single data read: A then 5 -> A5 at k+31, two 8-cycle E pulses.
    RS = 1; Poll = 0; D_in = 4'hA; Strb = 1; tick(); Strb = 0;
    ehi = 0; run = 0; maxrun = 0; runs = 0; vcyc = 0; vd = 0;
    for (n = 1; n <= 40; n++) begin
      if (n == 15) D_in = 4'h5;
      if (E) begin ehi++; run++; if (run == 1) runs++; if (run > maxrun) maxrun = run; end
      else run = 0;
      if (Valid) begin vcyc = n; vd = D_out; end
      tick();
    end
    chk("single_valid_cycle", vcyc, 31);
    chk("single_data", vd, 8'hA5);
    chk("single_e_total", ehi, 16);
    chk("single_e_width", maxrun, 8);
    chk("single_e_pulses", runs, 2);
    wait_idle("single");

    // Busy poll: high nibble 8 for three reads, then 3.
    RS = 0; Poll = 1; Strb = 1; tick(); Strb = 0; RS = 1; Poll = 0;
    erises = 0; vcnt = 0; prev_e = 0; vd = 0; vto = 0;
    for (n = 1; n <= 160; n++) begin
      if (E && !prev_e) erises++;
      prev_e = E;
      if (E && (erises % 2 == 1)) D_in = ((erises - 1) / 2 < 3) ? 4'h8 : 4'h3;
      else D_in = 4'($urandom);
      if (Valid) begin vcnt++; vd = D_out; vto = Timeout; end
      tick();
    end
    chk("poll_reads", erises, 8);
    chk("poll_valids", vcnt, 1);
    chk("poll_d7", vd[7], 0);
    chk("poll_hi", vd[7:4], 4'h3);
    chk("poll_timeout", vto, 0);
    wait_idle("poll");

    // Poll timeout: flag stuck high; the 7th decision sees the saturated count.
    RS = 0; Poll = 1; D_in = 4'hF; Strb = 1; tick(); Strb = 0;
    erises = 0; prev_e = 0; vd = 0; vto = 0; vbusy = 1; n = 0;
    while (!Valid && n < 400) begin
      if (E && !prev_e) erises++;
      prev_e = E; tick(); n++;
    end
    if (n >= 400) chk("to_valid_wait", 16'd1, 16'd0);
    vd = D_out; vto = Timeout; vbusy = Busy;
    chk("to_flag", vto, 1);
    chk("to_data", vd, 8'hFF);
    chk("to_busy", vbusy, 0);
    chk("to_reads", erises, 14);
    wait_idle("to");

    // Reset in the middle of ELO1.
    RS = 1; Poll = 0; Strb = 1; tick(); Strb = 0;
    for (n = 1; n < 15; n++) tick();
    Reset = 1; tick(); Reset = 0;
    chk("mid_rst_E", E, 0); chk("mid_rst_RW", RW, 0); chk("mid_rst_Busy", Busy, 0);
    chk("mid_rst_D_out", D_out, 8'h00);
    vcnt = 0;
    for (n = 0; n < 40; n++) begin if (Valid) vcnt++; tick(); end
    chk("mid_rst_no_valid", vcnt, 0);

    // Strb during Busy is ignored.
    RS = 1; Strb = 1; tick(); Strb = 0; vcnt = 0;
    for (n = 1; n <= 70; n++) begin
      if (n == 5) Strb = 1; else Strb = 0;
      D_in = 4'($urandom);
      if (Valid) vcnt++;
      tick();
    end
    chk("ignored_strb_valids", vcnt, 1);
    wait_idle("ign");

    // Strb held high: back-to-back reads, RW low for exactly one cycle between.
    Strb = 1; vcnt = 0; lowrun = 0; seen = 0;
    for (n = 0; n < 130; n++) begin
      D_in = 4'($urandom);
      if (Valid) vcnt++;
      if (RW) begin
        if (lowrun > 0) chk("b2b_rw_low", lowrun, 1);
        lowrun = 0; seen = 1;
      end else if (seen) lowrun++;
      tick();
    end
    Strb = 0;
    chk("b2b_valids", vcnt, 4);
    wait_idle("b2b");

    // Randomised transactions.
    for (int it = 0; it < 40; it++) begin
      RS = 1'($urandom); Poll = 1'($urandom);
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      Strb = 1; tick(); Strb = 0;
      n = 0;
      while ((Busy || n < 2) && n < 300) begin
        D_in = 4'($urandom);
        Strb = Busy && ($urandom_range(0, 19) == 0);
        RS = 1'($urandom); Poll = 1'($urandom);
        if ($urandom_range(0, 399) == 0) Reset = 1; else Reset = 0;
        tick(); n++;
      end
      Strb = 0; Reset = 0;
      if (n >= 300) chk("rand_busy_wait", 16'd1, 16'd0);
      tick();
    end

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_read.md
LCD_READ -- requirements
Module: lcd_read

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: RS/RW setup cycles before E rises (74 ns @ 27 MHz).
REQ-002 SHALL have parameter EHIGH_CYC, default 8: E high width in cycles (296 ns).
REQ-003 SHALL have parameter ELOW_CYC, default 10: E low cycles between the two nibbles.
REQ-004 SHALL have parameter HOLD_CYC, default 2: RW/RS hold cycles after the final E fall.
REQ-005 SHALL have parameter POLL_TIMEOUT, default 55000: busy-poll limit in cycles (2 ms).
REQ-006 SHALL have port Clk, input, 1: clock, 27 MHz, all logic on rising edge.
REQ-007 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port Strb, input, 1: start-read request, sampled only when idle.
REQ-009 SHALL have port RS, input, 1: register select for the read; 0 = busy flag/address, 1 = data RAM.
REQ-010 SHALL have port Poll, input, 1: with RS=0, repeat reads until the busy flag clears.
REQ-011 SHALL have port D_in, input, 4: LCD DB7..DB4, read nibble.
REQ-012 SHALL have port E, output, 1: LCD enable strobe.
REQ-013 SHALL have port RW, output, 1: LCD read/write; 1 = read, and the top level tristates DB7..DB4 while RW=1.
REQ-014 SHALL have port RS_out, output, 1: registered RS to the LCD.
REQ-015 SHALL have port Busy, output, 1: transaction in progress.
REQ-016 SHALL have port D_out, output, 8: assembled byte, high nibble first.
REQ-017 SHALL have port Valid, output, 1: one-cycle pulse; D_out is updated in the same cycle.
REQ-018 SHALL have port Timeout, output, 1: one-cycle pulse, asserted with Valid, when the poll limit expires.

Function
REQ-019 SHALL implement states IDLE, SETUP, EHI1, ELO1, EHI2, HOLD, DONE.
REQ-020 SHALL, in IDLE with Strb=1 at edge k: latch RS into RS_out, set RW=1, set Busy=1 from cycle k+1, and enter SETUP.
REQ-021 SHALL hold SETUP SETUP_CYC cycles, then EHI1 with E=1 for EHIGH_CYC cycles.
REQ-022 SHALL capture D_in into D_out staging bits [7:4] on the last EHI1 cycle, then set E=0.
REQ-023 SHALL hold ELO1 with E=0 for ELOW_CYC cycles, then EHI2 with E=1 for EHIGH_CYC cycles, capturing bits [3:0] on the last EHI2 cycle.
REQ-024 SHALL hold HOLD with E=0 for HOLD_CYC cycles, keeping RW=1 and RS_out stable.
REQ-025 SHALL, in DONE: copy staging to D_out, pulse Valid, clear RW and Busy, and return to IDLE; with default parameters Valid is at cycle k+31.
REQ-026 SHALL, when Poll=1, RS_out=0, staging bit 7=1 and the poll counter < POLL_TIMEOUT at HOLD end: go to SETUP instead of DONE, with RW kept high and no Valid.
REQ-027 SHALL keep a poll counter that clears on Strb acceptance and increments every Busy cycle, saturating at POLL_TIMEOUT.
REQ-028 SHALL, when the counter reaches POLL_TIMEOUT with the busy flag still 1: finish the current byte, then pulse Valid and Timeout together in DONE.
REQ-029 SHALL latch Poll at Strb acceptance; Poll with RS=1 SHALL be ignored (single read).
REQ-030 SHALL ignore Strb, RS, Poll while Busy=1; Strb held high SHALL start a new read in the cycle after DONE.
REQ-031 SHALL leave D_out unchanged except in DONE.
REQ-032 SHALL never assert E while RW=0.

Reset
REQ-033 SHALL, when Reset=1 at any edge (including mid-transaction), set the next state to: E=0, RW=0, RS_out=0, Busy=0, D_out=8'h00, Valid=0, Timeout=0, state IDLE, counters 0.
REQ-034 SHALL give Reset priority over a simultaneous Strb; that Strb is discarded.

Structure
REQ-035 SHALL place the state enum and default timing constants in shared package lcd_pkg, also used by the writer.
REQ-036 SHALL use one sub-module, lcd_cycle_timer: a loadable down-counter with a done flag that sequences per-state cycle counts.

Verification
REQ-037 SHALL cover: RS=1, Strb at k, D_in=4'hA during EHI1, 4'h5 during EHI2 -> D_out=8'hA5, Valid at k+31, E high exactly 8 cycles twice.
REQ-038 SHALL cover: RS=0, Poll=1, D_in high nibble 4'h8 for 3 reads then 4'h3 -> 4 byte reads, single Valid, D_out[7]=0, Timeout=0.
REQ-039 SHALL cover: POLL_TIMEOUT=200, D_in stuck at 4'hF, RS=0, Poll=1 -> Valid and Timeout pulse together, D_out=8'hFF, Busy falls.
REQ-040 SHALL cover: Reset at cycle k+15 -> E=0, RW=0, Busy=0 next cycle, D_out keeps 8'h00, no Valid.
REQ-041 SHALL cover: Strb pulsed at k+5 during Busy -> ignored; Strb held high -> back-to-back reads, RW drops for exactly the DONE cycle.
